// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, funct3 codes and LSU state encoding
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_MEM  = 2'd1,
        LSU_WB   = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } acc_size_e;

    // Reserved funct3 codes fall through to word accesses.
    function automatic acc_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_writeback_if.sv
// rtl/lsu_writeback_if.sv - execute, data-memory and register-file bundle (LSU_MISALIGN_TRAP_EN adds misalign)
interface lsu_writeback_if;
    import cpu_pkg::*;

    logic                  ex_valid;
    logic                  ex_ready;
    logic                  ex_is_load;
    logic                  ex_is_store;
    logic [2:0]            ex_funct3;
    logic [XLEN-1:0]       ex_addr;
    logic [XLEN-1:0]       ex_store_data;
    logic [XLEN-1:0]       ex_alu_result;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write;
    logic                  mem_req;
    logic                  mem_we;
    logic [XLEN-1:0]       mem_addr;
    logic [XLEN-1:0]       mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_ack;
    logic [XLEN-1:0]       mem_rdata;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]       rf_rd_din;
    logic                  rf_write_enable;
    logic                  stall;
    logic                  err;
`ifdef LSU_MISALIGN_TRAP_EN
    logic                  misalign;

    modport slave (
        input  ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr, ex_store_data,
               ex_alu_result, ex_rd, ex_reg_write, mem_ack, mem_rdata,
        output ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               rf_rd, rf_rd_din, rf_write_enable, stall, err, misalign
    );
    modport master (
        output ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr, ex_store_data,
               ex_alu_result, ex_rd, ex_reg_write, mem_ack, mem_rdata,
        input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               rf_rd, rf_rd_din, rf_write_enable, stall, err, misalign
    );
`else
    modport slave (
        input  ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr, ex_store_data,
               ex_alu_result, ex_rd, ex_reg_write, mem_ack, mem_rdata,
        output ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               rf_rd, rf_rd_din, rf_write_enable, stall, err
    );
    modport master (
        output ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr, ex_store_data,
               ex_alu_result, ex_rd, ex_reg_write, mem_ack, mem_rdata,
        input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               rf_rd, rf_rd_din, rf_write_enable, stall, err
    );
`endif

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load extract/extend, store strobe/lane generation, misalign detect (LSU_MISALIGN_TRAP_EN)
module lsu_align
    import cpu_pkg::*;
(
    input  logic [2:0]      i_ld_funct3,
    input  logic [1:0]      i_ld_off,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_ld_data,
    input  logic [2:0]      i_st_funct3,
    input  logic [1:0]      i_st_off,
    input  logic [XLEN-1:0] i_st_data,
    output logic [3:0]      o_wstrb,
    output logic [XLEN-1:0] o_wdata
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic            o_misalign
`endif
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Halfword lanes use only off[1], so a misaligned LH/SH lands on its natural boundary.
    always_comb begin
        w_byte = i_rdata[{i_ld_off, 3'b000} +: 8];
        w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_ld_data = {24'd0, w_byte};
            F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_ld_data = {16'd0, w_half};
            default: o_ld_data = i_rdata;
        endcase
    end

    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_st_data;
        case (f3_size(i_st_funct3))
            SZ_B: begin
                o_wstrb = 4'b0001 << i_st_off;
                o_wdata = {4{i_st_data[7:0]}};
            end
            SZ_H: begin
                o_wstrb = i_st_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign o_misalign = ((f3_size(i_st_funct3) == SZ_H) && i_st_off[0]) ||
                        ((f3_size(i_st_funct3) == SZ_W) && (i_st_off != 2'b00));
`endif

endmodule

// File: rtl/lsu_writeback.sv
// rtl/lsu_writeback.sv - load/store + writeback stage feeding the register file (LSU_MISALIGN_TRAP_EN traps misaligned accesses)
module lsu_writeback
    import cpu_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] STACK_BASE     = 32'h2ffc
) (
    input  logic           clk,
    input  logic           reset,
    lsu_writeback_if.slave bus
);

    localparam int              CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    generate
        if (TIMEOUT_CYCLES < 1 || STACK_BASE[1:0] != 2'b00) begin : g_bad_param
            $error("lsu_writeback: TIMEOUT_CYCLES must be >= 1 and STACK_BASE word aligned");
        end
    endgenerate

    lsu_state_e            r_state, w_next;
    logic [CNT_W-1:0]      r_tmo_cnt;
    logic                  r_is_load, r_reg_write;
    logic [2:0]            r_funct3;
    logic [1:0]            r_off;
    logic                  r_mem_req, r_mem_we, r_rf_we, r_err;
    logic [XLEN-1:0]       r_mem_addr, r_mem_wdata, r_rf_din;
    logic [3:0]            r_mem_wstrb;
    logic [REG_ADDR_W-1:0] r_rf_rd;
    logic [XLEN-1:0]       w_ld_data, w_wdata;
    logic [3:0]            w_wstrb;
    logic                  w_accept, w_is_mem, w_timeout, w_trap;

    lsu_align u_align (
        .i_ld_funct3 (r_funct3),
        .i_ld_off    (r_off),
        .i_rdata     (bus.mem_rdata),
        .o_ld_data   (w_ld_data),
        .i_st_funct3 (bus.ex_funct3),
        .i_st_off    (bus.ex_addr[1:0]),
        .i_st_data   (bus.ex_store_data),
        .o_wstrb     (w_wstrb),
        .o_wdata     (w_wdata)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .o_misalign  (w_trap)
`endif
    );

`ifndef LSU_MISALIGN_TRAP_EN
    assign w_trap = 1'b0;
`endif

    assign w_accept  = bus.ex_valid && (r_state == LSU_IDLE);
    assign w_is_mem  = bus.ex_is_load || bus.ex_is_store;
    assign w_timeout = (r_tmo_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) r_state <= LSU_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LSU_IDLE: if (w_accept && w_is_mem && !w_trap) w_next = LSU_MEM;
            LSU_MEM: begin
                if (bus.mem_ack)    w_next = r_is_load ? LSU_WB : LSU_IDLE;
                else if (w_timeout) w_next = LSU_IDLE;
            end
            default:                w_next = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tmo_cnt   <= '0;
            r_is_load   <= 1'b0;
            r_reg_write <= 1'b0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= 4'd0;
            r_rf_we     <= 1'b0;
            r_rf_rd     <= '0;
            r_rf_din    <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rf_we <= 1'b0;
            if (r_state == LSU_IDLE && w_accept) begin
                r_rf_rd <= bus.ex_rd;
                if (!w_is_mem) begin
                    r_rf_din <= bus.ex_alu_result;
                    r_rf_we  <= bus.ex_reg_write && (bus.ex_rd != '0);
                end else if (!w_trap) begin
                    // A load+store encoding is treated as a load.
                    r_is_load   <= bus.ex_is_load;
                    r_reg_write <= bus.ex_reg_write && (bus.ex_rd != '0);
                    r_funct3    <= bus.ex_funct3;
                    r_off       <= bus.ex_addr[1:0];
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= !bus.ex_is_load;
                    r_mem_addr  <= {bus.ex_addr[XLEN-1:2], 2'b00};
                    r_mem_wdata <= w_wdata;
                    r_mem_wstrb <= bus.ex_is_load ? 4'b0000 : w_wstrb;
                    r_tmo_cnt   <= '0;
                end
            end else if (r_state == LSU_MEM) begin
                if (bus.mem_ack) begin
                    r_mem_req <= 1'b0;
                    if (r_is_load) begin
                        r_rf_din <= w_ld_data;
                        r_rf_we  <= r_reg_write;
                    end
                end else if (w_timeout) begin
                    r_mem_req <= 1'b0;
                    r_err     <= 1'b1;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_misalign;
    always_ff @(posedge clk) begin
        if (!reset) r_misalign <= 1'b0;
        else        r_misalign <= w_accept && w_is_mem && w_trap;
    end
    assign bus.misalign = r_misalign;
`endif

    assign bus.ex_ready        = (r_state == LSU_IDLE);
    assign bus.stall           = (r_state != LSU_IDLE);
    assign bus.mem_req         = r_mem_req;
    assign bus.mem_we          = r_mem_we;
    assign bus.mem_addr        = r_mem_addr;
    assign bus.mem_wdata       = r_mem_wdata;
    assign bus.mem_wstrb       = r_mem_wstrb;
    assign bus.rf_rd           = r_rf_rd;
    assign bus.rf_rd_din       = r_rf_din;
    assign bus.rf_write_enable = r_rf_we;
    assign bus.err             = r_err;

endmodule
